// File: rtl/barrel_shift_issue_queue_pkg.sv
// Shared definitions for the barrel-shifter issue queue.
//   DW    : operand width (fixed at 8 to match the shifter)
//   AW    : rotate-amount width, log2(DW)
//   DEPTH : default request FIFO depth
//   req_t : one rotate request {data, amt}
//   rotr  : rotate-right reference, out[i] = d[(i+a) mod DW]
package barrel_shift_issue_queue_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] amt;
  } req_t;

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] d, input logic [AW-1:0] a);
    logic [2*DW-1:0] dd;
    dd = {d, d};
    return dd[a +: DW];
  endfunction

endpackage

// File: rtl/barrel_shift_issue_queue_sync_fifo.sv
// Synchronous FIFO with synchronous active-low reset.
//   clk, rst_n        : clock / reset (pointers and count cleared)
//   wr_en, wr_data    : write request (ignored when full)
//   rd_en, rd_data    : read request (ignored when empty); rd_data shows head
//   full, empty, count: status, count ranges 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // power-of-two depth: pointers wrap by natural overflow
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is not reset; only valid entries are ever read
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/barrel_shift_issue_queue.sv
// Registered front-end for the combinational 8-bit barrel shifter.
//   in_valid/in_ready/in_data/in_amt : request handshake into the FIFO
//   sh_d/sh_c                        : registered operand/amount to shifter
//   sh_q                             : shifter result (combinational)
//   out_valid/out_ready/out_data/out_amt : captured result handshake
//   count                            : FIFO occupancy
module barrel_shift_issue_queue
  import barrel_shift_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = barrel_shift_issue_queue_pkg::DEPTH,
  parameter int unsigned DW    = barrel_shift_issue_queue_pkg::DW,
  parameter int unsigned AW    = barrel_shift_issue_queue_pkg::AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic [AW-1:0]          in_amt,
  output logic [DW-1:0]          sh_d,
  output logic [AW-1:0]          sh_c,
  input  logic [DW-1:0]          sh_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [AW-1:0]          out_amt,
  output logic [$clog2(DEPTH):0] count
);

  logic [DW+AW-1:0] head;
  logic             fifo_full, fifo_empty;
  logic             push, advance, capture;

  logic [DW-1:0] sh_d_q, sh_d_d;
  logic [AW-1:0] sh_c_q, sh_c_d;
  logic          iss_v_q, iss_v_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_amt_q, out_amt_d;
  logic          out_valid_q, out_valid_d;

  // in_ready looks only at occupancy, so a full FIFO stalls input
  // even on a cycle where it is also being popped
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign capture  = iss_v_q && (!out_valid_q || out_ready);
  assign advance  = !fifo_empty && (!iss_v_q || capture);

  sync_fifo #(
    .WIDTH(DW + AW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data({in_data, in_amt}),
    .rd_en  (advance),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  always_comb begin
    sh_d_d      = sh_d_q;
    sh_c_d      = sh_c_q;
    iss_v_d     = iss_v_q;
    out_data_d  = out_data_q;
    out_amt_d   = out_amt_q;
    out_valid_d = out_valid_q;

    if (advance) begin
      sh_d_d  = head[DW+AW-1:AW];
      sh_c_d  = head[AW-1:0];
      iss_v_d = 1'b1;
    end else if (capture) begin
      // drained with nothing behind it: operand registers keep last value
      iss_v_d = 1'b0;
    end

    if (capture) begin
      out_data_d  = sh_q;
      out_amt_d   = sh_c_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_d_q      <= '0;
      sh_c_q      <= '0;
      iss_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_amt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sh_d_q      <= sh_d_d;
      sh_c_q      <= sh_c_d;
      iss_v_q     <= iss_v_d;
      out_data_q  <= out_data_d;
      out_amt_q   <= out_amt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sh_d      = sh_d_q;
  assign sh_c      = sh_c_q;
  assign out_data  = out_data_q;
  assign out_amt   = out_amt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shift_issue_queue.sv
// Directed and soak bench for barrel_shift_issue_queue with a behavioural
// rotate-right shifter connected between sh_d/sh_c and sh_q.
module tb_barrel_shift_issue_queue;
  import barrel_shift_issue_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [7:0] sh_d;
  logic [2:0] sh_c;
  logic [7:0] sh_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_amt;
  logic [2:0] count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // external shifter: out[i] = in[(i+amt) mod 8]
  always_comb begin
    sh_q = '0;
    for (int unsigned i = 0; i < 8; i++) sh_q[i] = sh_d[(i + sh_c) % 8];
  end

  barrel_shift_issue_queue #(.DEPTH(4), .DW(8), .AW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .sh_d     (sh_d),
    .sh_c     (sh_c),
    .sh_q     (sh_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_amt  (out_amt),
    .count    (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [7:0] d, input logic [2:0] a);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] bp_d   [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hC3, 8'hA5};
  logic [2:0] bp_a   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [7:0] bp_exp [6] = '{8'h12, 8'h1A, 8'h95, 8'h0F, 8'h3C, 8'h2D};

  logic [7:0] sp_d   [4] = '{8'h01, 8'h03, 8'hF0, 8'h0F};
  logic [2:0] sp_a   [4] = '{3'd1, 3'd1, 3'd4, 3'd2};

  req_t exp_q[$];
  req_t e;
  int sent, recv, cyc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b1;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sh_d", 32'(sh_d), 0);
    chk("rst_sh_c", 32'(sh_c), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_amt", 32'(out_amt), 0);
    rst_n = 1'b1;

    // single request latency
    push_req(8'h01, 3'd1);
    chk("t1_count", 32'(count), 1);
    tick();
    chk("t1_sh_d", 32'(sh_d), 32'h01);
    chk("t1_sh_c", 32'(sh_c), 1);
    chk("t1_out_valid_early", 32'(out_valid), 0);
    tick();
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_data", 32'(out_data), 32'h80);
    chk("t1_out_amt", 32'(out_amt), 1);
    tick();
    chk("t1_out_drained", 32'(out_valid), 0);

    // back-to-back stream
    push_req(8'hB4, 3'd3);
    push_req(8'hB4, 3'd0);
    push_req(8'hF0, 3'd4);
    chk("t2_v0", 32'(out_valid), 1);
    chk("t2_d0", 32'(out_data), 32'h96);
    chk("t2_a0", 32'(out_amt), 3);
    tick();
    chk("t2_v1", 32'(out_valid), 1);
    chk("t2_d1", 32'(out_data), 32'hB4);
    chk("t2_a1", 32'(out_amt), 0);
    tick();
    chk("t2_v2", 32'(out_valid), 1);
    chk("t2_d2", 32'(out_data), 32'h0F);
    chk("t2_a2", 32'(out_amt), 4);
    tick();
    chk("t2_idle", 32'(out_valid), 0);

    // back-pressure fill: 1 held + 1 issued + 4 queued
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t3_ready_before_push", 32'(in_ready), 1);
      push_req(bp_d[k], bp_a[k]);
    end
    chk("t3_full_ready", 32'(in_ready), 0);
    chk("t3_full_count", 32'(count), 4);
    chk("t3_hold_valid", 32'(out_valid), 1);
    chk("t3_hold_data", 32'(out_data), 32'h12);
    push_req(8'hFF, 3'd1);
    tick();
    chk("t3_no_overflow", 32'(count), 4);
    chk("t3_stable_data", 32'(out_data), 32'h12);
    chk("t3_stable_amt", 32'(out_amt), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t3_drain_valid", 32'(out_valid), 1);
      chk("t3_drain_data", 32'(out_data), 32'(bp_exp[k]));
      chk("t3_drain_amt", 32'(out_amt), 32'(bp_a[k]));
      tick();
    end
    chk("t3_empty_valid", 32'(out_valid), 0);
    chk("t3_empty_count", 32'(count), 0);

    // simultaneous push and pop at count==2
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_req(sp_d[k], sp_a[k]);
    chk("t4_count_pre", 32'(count), 2);
    chk("t4_held", 32'(out_data), 32'h80);
    out_ready = 1'b1;
    push_req(8'h80, 3'd7);
    chk("t4_count_same", 32'(count), 2);
    chk("t4_d1", 32'(out_data), 32'h81);
    tick();
    chk("t4_d2", 32'(out_data), 32'h0F);
    tick();
    chk("t4_d3", 32'(out_data), 32'hC3);
    tick();
    chk("t4_d4", 32'(out_data), 32'h01);
    chk("t4_a4", 32'(out_amt), 7);
    tick();
    chk("t4_done", 32'(out_valid), 0);

    // reset mid-operation
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_req(bp_d[k], bp_a[k]);
    chk("t5_pre_count", 32'(count), 3);
    chk("t5_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    push_req(8'h81, 3'd7);
    tick();
    tick();
    chk("t5_post_valid", 32'(out_valid), 1);
    chk("t5_post_data", 32'(out_data), 32'h03);
    chk("t5_post_amt", 32'(out_amt), 7);
    tick();
    chk("t5_no_extra", 32'(out_valid), 0);

    // random soak
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back('{data: rotr(in_data, in_amt), amt: in_amt});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("soak_underflow", 32'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("soak_data", 32'(out_data), 32'(e.data));
          chk("soak_amt", 32'(out_amt), 32'(e.amt));
        end
        recv++;
      end
      if (count > 3'd4) chk("soak_count_range", 32'(count), 4);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("soak_received", 32'(recv), 1000);
    chk("soak_leftover", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
